// File: rtl/bcd_entry_register.sv
// -----------------------------------------------------------------------------
// bcd_entry_register
//
// Keypad digit-entry register for the calculator datapath. Keycodes arrive
// from the keypad scanner together with a level keystrobe. The strobe is
// edge-detected here, so each key press produces exactly one action,
// however long the key is held.
//
// The entry is held as DIGITS packed BCD digits. Digit keys shift in at the
// least-significant end, BACK deletes the least-significant digit and CLEAR
// empties the entry. A digit pressed while the entry is full is dropped and
// raises a sticky overflow flag. A registered blank mask suppresses leading
// zeros on the 7-segment displays.
//
// ENTER snapshots the entry and converts it to binary with one
// multiply-by-ten-and-add step per clock. The result appears DIGITS clocks
// after the capturing edge, together with a one-cycle valid pulse.
//
// Ports
//   clock        in   1                 system clock, rising-edge active
//   reset        in   1                 synchronous, active-high reset
//   digit        in   4                 keycode, valid while keystrobe is high
//   keystrobe    in   1                 level, high while a key is held
//   bcd          out  4*DIGITS          packed BCD, digit i at [4i+3:4i]
//   blank        out  DIGITS            per-digit leading-zero blank mask
//   count        out  clog2(DIGITS+1)   number of significant digits entered
//   overflow     out  1                 sticky: a digit was rejected (entry full)
//   value        out  BIN_WIDTH         last converted binary value
//   value_valid  out  1                 one-cycle pulse when value updates
//   busy         out  1                 conversion in progress
// -----------------------------------------------------------------------------
module bcd_entry_register #(
    parameter int         DIGITS     = 3,
    parameter int         BIN_WIDTH  = 10,
    parameter logic [3:0] CLEAR_CODE = 4'hE,
    parameter logic [3:0] BACK_CODE  = 4'hF,
    parameter logic [3:0] ENTER_CODE = 4'hA
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [3:0]                   digit,
    input  logic                         keystrobe,
    output logic [4*DIGITS-1:0]          bcd,
    output logic [DIGITS-1:0]            blank,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         overflow,
    output logic [BIN_WIDTH-1:0]         value,
    output logic                         value_valid,
    output logic                         busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int STEP_W = $clog2(DIGITS + 1);

    // An empty entry blanks every digit except digit 0, so the display
    // shows a single "0".
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    // -------------------------------------------------------------------------
    // Keystrobe edge detection and key decode
    // -------------------------------------------------------------------------
    logic r_strobe_d;
    logic w_key_event;
    logic w_is_numeric;
    logic w_is_digit;
    logic w_is_clear;
    logic w_is_back;
    logic w_is_enter;

    // The delayed strobe resets high: a key still held when reset is
    // released looks "already seen" and is not accepted.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before the clock edge.
        if (reset) begin
            r_strobe_d <= 1'b1;
        end else begin
            r_strobe_d <= keystrobe;
        end
    end

    assign w_key_event  = keystrobe & ~r_strobe_d;
    assign w_is_numeric = (digit <= 4'd9);

    // Codes 0-9 are always digits. Among the command codes, CLEAR wins over
    // BACK, and BACK wins over ENTER, in case parameters collide.
    assign w_is_digit = w_key_event & w_is_numeric;
    assign w_is_clear = w_key_event & ~w_is_numeric & (digit == CLEAR_CODE);
    assign w_is_back  = w_key_event & ~w_is_numeric & (digit == BACK_CODE)
                        & ~w_is_clear;
    assign w_is_enter = w_key_event & ~w_is_numeric & (digit == ENTER_CODE)
                        & ~w_is_clear & ~w_is_back;

    // -------------------------------------------------------------------------
    // Entry register: bcd, count, overflow, blank mask
    // -------------------------------------------------------------------------
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [DIGITS-1:0] r_blank;

    logic [BCD_W-1:0]  w_bcd_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_overflow_next;
    logic [DIGITS-1:0] w_blank_next;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_bcd_next      = r_bcd;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;

        if (w_is_clear) begin
            w_bcd_next      = '0;
            w_count_next    = '0;
            w_overflow_next = 1'b0;
        end else if (w_is_back) begin
            w_bcd_next      = r_bcd >> 4;
            w_overflow_next = 1'b0;
            if (r_count != '0) begin
                w_count_next = r_count - 1'b1;
            end
        end else if (w_is_digit) begin
            // A zero typed into an empty entry is a leading zero: drop it.
            if (!((r_count == '0) && (digit == 4'd0))) begin
                if (r_count < CNT_W'(DIGITS)) begin
                    w_bcd_next   = (r_bcd << 4) | BCD_W'(digit);
                    w_count_next = r_count + 1'b1;
                end else begin
                    w_overflow_next = 1'b1;
                end
            end
        end
    end

    // The blank mask is derived from the next count, so it is registered in
    // the same cycle as count. Digit 0 is never blanked.
    always_comb begin
        w_blank_next = '0;
        for (int i = 1; i < DIGITS; i++) begin
            w_blank_next[i] = (i >= int'(w_count_next));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bcd      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_blank    <= BLANK_RST;
        end else begin
            r_bcd      <= w_bcd_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
            r_blank    <= w_blank_next;
        end
    end

    // -------------------------------------------------------------------------
    // Conversion control FSM
    // -------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic              w_busy;
    logic              w_conv_start;
    logic              w_conv_last;
    logic [STEP_W-1:0] r_step;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ENTER is only honoured from IDLE, so an ENTER during a conversion is
    // dropped rather than queued or restarting the conversion.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_conv_start = 1'b0;
        w_conv_last  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_is_enter) begin
                    w_conv_start = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                w_busy = 1'b1;
                if (r_step == STEP_W'(DIGITS - 1)) begin
                    w_conv_last  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Conversion datapath
    // -------------------------------------------------------------------------
    // The conversion works on a private snapshot, so digit, BACK and CLEAR
    // keys may edit the live entry while it runs.
    logic [BCD_W-1:0]     r_snap;
    logic [BIN_WIDTH-1:0] r_acc;
    logic [BIN_WIDTH-1:0] r_value;
    logic                 r_value_valid;
    logic [3:0]           w_msd;
    logic [BIN_WIDTH-1:0] w_acc_next;

    assign w_msd = r_snap[BCD_W-1 -: 4];

    // Horner step, truncated to BIN_WIDTH bits.
    assign w_acc_next = (r_acc * BIN_WIDTH'(10)) + BIN_WIDTH'(w_msd);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_snap        <= '0;
            r_acc         <= '0;
            r_step        <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            if (w_conv_start) begin
                r_snap <= r_bcd;
                r_acc  <= '0;
                r_step <= '0;
            end else if (w_busy) begin
                r_acc  <= w_acc_next;
                r_snap <= r_snap << 4;
                r_step <= r_step + 1'b1;
                // The last step's sum goes straight to value, so the
                // result lands DIGITS clocks after the capturing edge.
                if (w_conv_last) begin
                    r_value       <= w_acc_next;
                    r_value_valid <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bcd         = r_bcd;
    assign blank       = r_blank;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign busy        = w_busy;

endmodule

// File: tb/tb_bcd_entry_register.sv
// -----------------------------------------------------------------------------
// tb_bcd_entry_register
//
// Self-checking bench for bcd_entry_register with the default parameters
// (DIGITS=3, BIN_WIDTH=10, CLEAR=E, BACK=F, ENTER=A). Entry editing is
// driven from a table of key presses and the expected entry state after
// each one. Conversion timing, keys pressed during a conversion, and reset
// during a conversion are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bcd_entry_register;

    localparam logic [3:0] K_CLEAR = 4'hE;
    localparam logic [3:0] K_BACK  = 4'hF;
    localparam logic [3:0] K_ENTER = 4'hA;

    logic        clock;
    logic        reset;
    logic [3:0]  digit;
    logic        keystrobe;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic [1:0]  count;
    logic        overflow;
    logic [9:0]  value;
    logic        value_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    bcd_entry_register dut (
        .clock       (clock),
        .reset       (reset),
        .digit       (digit),
        .keystrobe   (keystrobe),
        .bcd         (bcd),
        .blank       (blank),
        .count       (count),
        .overflow    (overflow),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // One key press: the strobe is held high for `hold` cycles, then low
    // for two cycles so that the next press is seen as a new edge.
    task automatic press(input logic [3:0] code, input int hold);
        @(negedge clock);
        digit     = code;
        keystrobe = 1'b1;
        repeat (hold) @(negedge clock);
        keystrobe = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic check_entry(input string tag, input logic [11:0] e_bcd,
                               input logic [1:0] e_cnt, input logic [2:0] e_blank,
                               input logic e_ovf);
        check({tag, ".bcd"},      32'(bcd),      32'(e_bcd));
        check({tag, ".count"},    32'(count),    32'(e_cnt));
        check({tag, ".blank"},    32'(blank),    32'(e_blank));
        check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [11:0] bcd;
        logic [1:0]  cnt;
        logic [2:0]  blank;
        logic        ovf;
    } vec_t;

    localparam int N_VEC = 22;
    vec_t vecs [N_VEC];

    initial begin
        // Expected entry state after each key press, in order.
        vecs[0]  = '{4'h1,    12'h001, 2'd1, 3'b110, 1'b0};
        vecs[1]  = '{4'h2,    12'h012, 2'd2, 3'b100, 1'b0};
        vecs[2]  = '{4'h3,    12'h123, 2'd3, 3'b000, 1'b0};
        vecs[3]  = '{4'h4,    12'h123, 2'd3, 3'b000, 1'b1}; // full: overflow
        vecs[4]  = '{K_BACK,  12'h012, 2'd2, 3'b100, 1'b0};
        vecs[5]  = '{4'h5,    12'h125, 2'd3, 3'b000, 1'b0};
        vecs[6]  = '{4'h9,    12'h125, 2'd3, 3'b000, 1'b1};
        vecs[7]  = '{4'hB,    12'h125, 2'd3, 3'b000, 1'b1}; // unassigned code
        vecs[8]  = '{K_CLEAR, 12'h000, 2'd0, 3'b110, 1'b0};
        vecs[9]  = '{4'h0,    12'h000, 2'd0, 3'b110, 1'b0}; // leading zero
        vecs[10] = '{4'h0,    12'h000, 2'd0, 3'b110, 1'b0};
        vecs[11] = '{4'hC,    12'h000, 2'd0, 3'b110, 1'b0};
        vecs[12] = '{4'h7,    12'h007, 2'd1, 3'b110, 1'b0};
        vecs[13] = '{4'h0,    12'h070, 2'd2, 3'b100, 1'b0};
        vecs[14] = '{4'hD,    12'h070, 2'd2, 3'b100, 1'b0};
        vecs[15] = '{K_ENTER, 12'h070, 2'd2, 3'b100, 1'b0}; // ENTER keeps entry
        vecs[16] = '{K_BACK,  12'h007, 2'd1, 3'b110, 1'b0};
        vecs[17] = '{K_BACK,  12'h000, 2'd0, 3'b110, 1'b0};
        vecs[18] = '{K_BACK,  12'h000, 2'd0, 3'b110, 1'b0}; // saturates at 0
        vecs[19] = '{4'h8,    12'h008, 2'd1, 3'b110, 1'b0};
        vecs[20] = '{4'h0,    12'h080, 2'd2, 3'b100, 1'b0};
        vecs[21] = '{K_CLEAR, 12'h000, 2'd0, 3'b110, 1'b0};

        reset     = 1'b1;
        keystrobe = 1'b1;
        digit     = 4'h1;

        // ---- Key held through reset release must not be accepted ----------
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_entry("held_through_reset", 12'h000, 2'd0, 3'b110, 1'b0);
        check("reset.value",       32'(value),       32'd0);
        check("reset.value_valid", 32'(value_valid), 32'd0);
        check("reset.busy",        32'(busy),        32'd0);
        keystrobe = 1'b0;
        repeat (2) @(negedge clock);

        // ---- Table-driven entry editing -----------------------------------
        for (int i = 0; i < N_VEC; i++) begin
            press(vecs[i].code, 4);
            check_entry($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].cnt,
                        vecs[i].blank, vecs[i].ovf);
        end
        // Let the conversion started by vecs[15] (value 70) finish.
        repeat (4) @(negedge clock);
        check("enter070.value", 32'(value), 32'd70);

        // ---- 999 conversion: latency and busy window ----------------------
        press(4'h9, 2);
        press(4'h9, 2);
        press(4'h9, 2);
        check_entry("e999", 12'h999, 2'd3, 3'b000, 1'b0);
        digit     = K_ENTER;
        keystrobe = 1'b1;                           // captured at edge E
        @(negedge clock);
        keystrobe = 1'b0;
        check("c999.busy_E",    32'(busy),        32'd1);
        check("c999.valid_E",   32'(value_valid), 32'd0);
        @(negedge clock);
        check("c999.busy_E1",   32'(busy),        32'd1);
        @(negedge clock);
        check("c999.busy_E2",   32'(busy),        32'd1);
        check("c999.valid_E2",  32'(value_valid), 32'd0);
        check("c999.value_E2",  32'(value),       32'd70);
        @(negedge clock);
        check("c999.busy_E3",   32'(busy),        32'd0);
        check("c999.valid_E3",  32'(value_valid), 32'd1);
        check("c999.value_E3",  32'(value),       32'd999);
        @(negedge clock);
        check("c999.valid_E4",  32'(value_valid), 32'd0);
        check("c999.value_E4",  32'(value),       32'd999);
        check_entry("c999.entry", 12'h999, 2'd3, 3'b000, 1'b0);

        // ---- Digit entered while converting 042 ---------------------------
        press(K_CLEAR, 1);
        press(4'h4, 1);
        press(4'h2, 1);
        digit     = K_ENTER;
        keystrobe = 1'b1;                           // edge E
        @(negedge clock);
        keystrobe = 1'b0;
        @(negedge clock);                           // after E+1
        digit     = 4'h7;
        keystrobe = 1'b1;                           // accepted at E+2
        @(negedge clock);
        keystrobe = 1'b0;
        check("c042.busy_E2",   32'(busy),        32'd1);
        check("c042.bcd_E2",    32'(bcd),         32'h427);
        @(negedge clock);
        check("c042.value",     32'(value),       32'd42);
        check("c042.valid",     32'(value_valid), 32'd1);
        check("c042.busy_E3",   32'(busy),        32'd0);
        check_entry("c042.entry", 12'h427, 2'd3, 3'b000, 1'b0);

        // ---- Second ENTER while busy is ignored ---------------------------
        @(negedge clock);
        digit     = K_ENTER;
        keystrobe = 1'b1;                           // edge E
        @(negedge clock);
        keystrobe = 1'b0;
        @(negedge clock);
        keystrobe = 1'b1;                           // ENTER at E+2, busy
        @(negedge clock);
        keystrobe = 1'b0;
        check("c427.busy_E2",   32'(busy),        32'd1);
        @(negedge clock);
        check("c427.value",     32'(value),       32'd427);
        check("c427.valid",     32'(value_valid), 32'd1);
        check("c427.busy_E3",   32'(busy),        32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("c427.no_restart_busy%0d", k),  32'(busy),        32'd0);
            check($sformatf("c427.no_restart_valid%0d", k), 32'(value_valid), 32'd0);
        end

        // ---- Leading zeros, then reset during a conversion ----------------
        press(K_CLEAR, 1);
        press(4'h0, 2);
        press(4'h0, 2);
        check_entry("zeros", 12'h000, 2'd0, 3'b110, 1'b0);
        press(4'h5, 1);
        digit     = K_ENTER;
        keystrobe = 1'b1;                           // edge E
        @(negedge clock);
        keystrobe = 1'b0;
        check("rst.busy_E", 32'(busy), 32'd1);
        reset = 1'b1;                               // sampled at E+1
        @(negedge clock);
        check("rst.value",  32'(value),       32'd0);
        check("rst.busy",   32'(busy),        32'd0);
        check("rst.valid",  32'(value_valid), 32'd0);
        check_entry("rst.entry", 12'h000, 2'd0, 3'b110, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("rst.post_valid%0d", k), 32'(value_valid), 32'd0);
            check($sformatf("rst.post_busy%0d", k),  32'(busy),        32'd0);
        end
        check("rst.post_value", 32'(value), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_entry_register.md
Name: bcd_entry_register

Overview:
- Parametrised keypad digit-entry register for the calculator datapath.
- Accepts keycodes plus a level keystrobe from the keypad scanner and edge-detects the strobe internally.
- Maintains DIGITS packed BCD digits, supporting digit shift-in, backspace, clear, overflow flagging and leading-zero blanking.
- On ENTER, runs a sequential BCD-to-binary conversion and presents the result with a one-cycle valid pulse; feeds char_7seg displays and the downstream ALU.

Parameters:
DIGITS, 3, number of BCD digits held (>=1)
BIN_WIDTH, 10, binary result width; must be >= ceil(log2(10^DIGITS))
CLEAR_CODE, 4'hE, keycode that clears the entry
BACK_CODE, 4'hF, keycode that deletes the least-significant digit
ENTER_CODE, 4'hA, keycode that starts binary conversion

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
digit  input  4  keycode from scanner; valid while keystrobe high
keystrobe  input  1  level, high while a key is held
bcd  output  4*DIGITS  packed BCD; digit i at [4i+3:4i], digit 0 least significant
blank  output  DIGITS  per-digit blank mask for leading-zero suppression
count  output  $clog2(DIGITS+1)  number of significant digits entered
overflow  output  1  sticky: a digit was rejected because the entry was full
value  output  BIN_WIDTH  last converted binary value
value_valid  output  1  one-cycle pulse when value updates
busy  output  1  conversion in progress

Behaviour:
- Reset values: bcd=0, count=0, overflow=0, value=0, value_valid=0, busy=0, blank={DIGITS-1 ones, 0}, conversion state idle. The internal strobe-delay register resets to 1, so a key held through reset release is not accepted.
- Key event: the single cycle in which keystrobe=1 and the delayed keystrobe=0. Exactly one action per press, however long the key is held. digit is sampled in that cycle.
- Digit key 0-9:
  - count==0 and digit==0: ignored; bcd stays 0.
  - count<DIGITS: bcd <= {bcd[4*DIGITS-5:0], digit}, count+1.
  - count==DIGITS: bcd unchanged, overflow<=1.
- BACK_CODE:
  - bcd <= {4'h0, bcd[4*DIGITS-1:4]}.
  - count <= count-1, saturating at 0.
  - overflow<=0.
- CLEAR_CODE: bcd<=0, count<=0, overflow<=0. value is not cleared. An in-flight conversion continues unaffected.
- ENTER_CODE with busy=0 (edge E):
  - Snapshot bcd into an internal shift copy; acc<=0; busy<=1.
  - Edges E+1..E+DIGITS: acc <= acc*10 + (most-significant snapshot digit), then snapshot shifts left by 4. Arithmetic is BIN_WIDTH-bit, truncating.
  - At edge E+DIGITS: value<=final acc, value_valid<=1, busy<=0.
  - At edge E+DIGITS+1: value_valid<=0.
  - Latency is DIGITS clocks from the capturing edge. busy is high for exactly DIGITS cycles.
- ENTER_CODE with busy=1: ignored. No queuing, no restart.
- Digit/back/clear events during busy are applied to bcd normally. They do not affect the running conversion, which uses the snapshot.
- ENTER does not alter bcd or count.
- Unassigned codes (B, C, D with defaults): ignored, no state change.
- If parameter codes collide, priority is CLEAR > BACK > ENTER > digit. Digit values 0-9 are always digits, so codes set to 0-9 never match CLEAR/BACK/ENTER.
- Blank mask: blank[i]=1 iff i>=count and i!=0, so digit 0 always shows (displays "0" when empty). Registered, updated in the same cycle as count.
- Reset asserted mid-conversion: aborts; all outputs return to reset values at the next edge; value_valid is not pulsed.
- Only one key event per clock is possible; there are no simultaneous-key cases.

Test Plan:
- Reset with keystrobe held high, release reset, hold 5 cycles -> no key accepted; bcd=0, count=0, blank=3'b110.
- Press 1, 2, 3 (each strobe 4 cycles high) -> bcd=12'h123, count=3, blank=3'b000. Press 4 -> bcd unchanged, overflow=1.
- From 12'h123 press BACK -> bcd=12'h012, count=2, overflow=0, blank=3'b100. Press CLEAR -> bcd=0, count=0.
- Enter 9,9,9, then ENTER at edge E -> busy high for cycles E..E+2, value=999 and value_valid=1 only after edge E+3, then value_valid=0.
- During conversion of 12'h042, press 7 and a second ENTER -> value=42, busy drops on schedule, no second conversion; bcd=12'h427.
- Press 0 twice from empty -> count=0, bcd=0. Start conversion then assert reset at E+1 -> value=0, busy=0, no value_valid pulse.
